// File: rtl/pb_input_port.sv
// pb_input_port
//   Debounced pushbutton input port for the uP pushbuttons input. Each raw
//   switch bit passes through a synchroniser chain and then a per-bit
//   debounce state machine with a consecutive-cycle counter.
//
//   Optional feature macro: PB_EDGE_LATCH_EN
//     defined   : pushbuttons shows sticky press flags, which rd_strobe clears.
//                 If a set and a clear hit the same bit on the same edge, the
//                 set wins.
//     undefined : pushbuttons shows the debounced level, any_pending is 0 and
//                 rd_strobe is ignored.
//
//   Ports
//     clock       in  1      single clock; all state changes on the rising edge
//     reset       in  1      asynchronous, active-low reset
//     buttons_raw in  WIDTH  asynchronous switch inputs, 1 = pressed
//     rd_strobe   in  1      one-cycle read acknowledge from the CPU
//     pushbuttons out WIDTH  value presented to uP.pushbuttons
//     stable      out WIDTH  debounced level
//     press_event out WIDTH  one-cycle pulse after each debounced 0->1 change
//     any_pending out 1      OR of the sticky flags (0 without the latch)
//
//   Every output comes straight from a register or a decode of state
//   registers, so there is no combinational path from inputs to outputs.
module pb_input_port #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] buttons_raw,
   input  logic             rd_strobe,
   output logic [WIDTH-1:0] pushbuttons,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] press_event,
   output logic             any_pending
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b10,
      WAIT_LO   = 2'b11
   } db_state_t;

   logic [WIDTH-1:0] stable_d;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   sync_out;
         db_state_t              state_reg, state_next;
         logic [CNT_W-1:0]       cnt_reg, cnt_next;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sync_reg  <= '0;
               state_reg <= STABLE_LO;
               cnt_reg   <= '0;
            end else begin
               sync_reg  <= {sync_reg[SYNC_STAGES-2:0], buttons_raw[gi]};
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
            end
         end

         assign sync_out = sync_reg[SYNC_STAGES-1];

         // The edge that leaves a STABLE state already counts as the first
         // disagreeing edge, so the level flips on the DEBOUNCE_CYCLES-th one.
         always_comb begin
            state_next = state_reg;
            cnt_next   = '0;
            case (state_reg)
               STABLE_LO: begin
                  if (sync_out) begin
                     state_next = WAIT_HI;
                     cnt_next   = CNT_ONE;
                  end
               end
               WAIT_HI: begin
                  if (!sync_out)
                     state_next = STABLE_LO;
                  else if (cnt_reg == CNT_LAST)
                     state_next = STABLE_HI;
                  else
                     cnt_next = cnt_reg + CNT_ONE;
               end
               STABLE_HI: begin
                  if (!sync_out) begin
                     state_next = WAIT_LO;
                     cnt_next   = CNT_ONE;
                  end
               end
               WAIT_LO: begin
                  if (sync_out)
                     state_next = STABLE_HI;
                  else if (cnt_reg == CNT_LAST)
                     state_next = STABLE_LO;
                  else
                     cnt_next = cnt_reg + CNT_ONE;
               end
               default: state_next = STABLE_LO;
            endcase
         end

         // The debounced level is high in STABLE_HI and while a fall is
         // still being qualified.
         assign stable[gi] = (state_reg == STABLE_HI) || (state_reg == WAIT_LO);
      end
   endgenerate

   // Rising-edge detect on the debounced level, registered one cycle late.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stable_d    <= '0;
         press_event <= '0;
      end else begin
         stable_d    <= stable;
         press_event <= stable & ~stable_d;
      end
   end

`ifdef PB_EDGE_LATCH_EN
   logic [WIDTH-1:0] flag_reg;

   // The set term is ORed in after the clear, so a press on the same edge
   // as an acknowledge is not lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         flag_reg <= '0;
      else
         flag_reg <= (flag_reg & ~{WIDTH{rd_strobe}}) | press_event;
   end

   assign pushbuttons = flag_reg;
   assign any_pending = |flag_reg;
`else
   logic unused_rd_strobe;

   assign unused_rd_strobe = rd_strobe;
   assign pushbuttons      = stable;
   assign any_pending      = 1'b0;
`endif

endmodule

// File: tb/tb_pb_input_port.sv
// Testbench for pb_input_port (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A behavioural model predicts every output after each clock edge. The model
// delays the raw input by SYNC_STAGES samples. A level change is accepted
// once the last DEBOUNCE_CYCLES samples since the previous change all disagree
// with the current level. Directed scenarios are followed by random stimulus.
// The bench works with the latch macro either defined or undefined.
module tb_pb_input_port;
   localparam int W = 4;
   localparam int S = 2;
   localparam int D = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] buttons_raw = '0;
   logic         rd_strobe = 1'b0;
   logic [W-1:0] pushbuttons, stable, press_event;
   logic         any_pending;

   pb_input_port #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
      .clock       (clock),
      .reset       (reset),
      .buttons_raw (buttons_raw),
      .rd_strobe   (rd_strobe),
      .pushbuttons (pushbuttons),
      .stable      (stable),
      .press_event (press_event),
      .any_pending (any_pending)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_delay [S];    // raw value delayed by S samples
   logic [W-1:0] m_hist [$];     // last D samples seen by the debouncer
   int           m_since [W];    // samples since the last accepted change
   logic [W-1:0] m_stable, m_stable_old, m_press, m_flags;

   task automatic model_reset();
      for (int k = 0; k < S; k++) m_delay[k] = '0;
      m_hist.delete();
      for (int i = 0; i < W; i++) m_since[i] = 0;
      m_stable = '0; m_stable_old = '0; m_press = '0; m_flags = '0;
   endtask

   task automatic model_edge(input logic [W-1:0] raw, input logic rd);
      logic [W-1:0] samp, new_st;
      logic         all_diff;
      samp = m_delay[S-1];
      for (int k = S - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
      m_delay[0] = raw;
      m_hist.push_back(samp);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      new_st = m_stable;
      for (int i = 0; i < W; i++) begin
         m_since[i]++;
         if (m_since[i] >= D) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
               if (m_hist[m_hist.size()-1-j][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) begin
               new_st[i]  = ~m_stable[i];
               m_since[i] = 0;
            end
         end
      end
      m_flags      = (m_flags & ~{W{rd}}) | m_press;
      m_press      = m_stable & ~m_stable_old;
      m_stable_old = m_stable;
      m_stable     = new_st;
   endtask

   function automatic logic [W-1:0] exp_pushbuttons();
`ifdef PB_EDGE_LATCH_EN
      return m_flags;
`else
      return m_stable;
`endif
   endfunction

   function automatic logic exp_any();
`ifdef PB_EDGE_LATCH_EN
      return |m_flags;
`else
      return 1'b0;
`endif
   endfunction

   task automatic compare_all();
      check_eq("stable", stable, m_stable);
      check_eq("press_event", press_event, m_press);
      check_eq("pushbuttons", pushbuttons, exp_pushbuttons());
      check_eq("any_pending", {3'b000, any_pending}, {3'b000, exp_any()});
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic [W-1:0] raw, input logic rd);
      buttons_raw = raw;
      rd_strobe   = rd;
      @(posedge clock);
      model_edge(raw, rd);
      #1;
      compare_all();
      @(negedge clock);
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (n) begin
         @(posedge clock);
         #1;
         compare_all();
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   logic [W-1:0] ev_or;
   int           ev_cnt;
   logic [W-1:0] pat;
   int           hold;

   initial begin
      model_reset();
      @(negedge clock);

      // Reset with a held input: re-qualified after release.
      buttons_raw = 4'b0101;
      apply_reset(3);
      for (int e = 1; e <= 8; e++) begin
         step(4'b0101, 1'b0);
         if (e == 5) check_eq("held_stable_e5", stable, 4'b0000);
         if (e == 6) check_eq("held_stable_e6", stable, 4'b0101);
         if (e == 7) check_eq("held_event_e7", press_event, 4'b0101);
         if (e == 8) check_eq("held_event_e8", press_event, 4'b0000);
      end
      for (int e = 0; e < 8; e++) step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      check_eq("ack_clear", pushbuttons, 4'b0000);

      // Glitch shorter than the debounce window.
      ev_or = '0;
      for (int e = 0; e < 11; e++) begin
         step((e < 3) ? 4'b0001 : 4'b0000, 1'b0);
         ev_or |= press_event;
      end
      check_eq("glitch_stable", stable, 4'b0000);
      check_eq("glitch_event", ev_or, 4'b0000);
      check_eq("glitch_pb", pushbuttons, 4'b0000);

      // Bounce on bit 2, then held.
      ev_or = '0; ev_cnt = 0;
      for (int e = 0; e < 5; e++) begin
         step((e % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
         if (press_event != 0) ev_cnt++;
         ev_or |= press_event;
      end
      for (int j = 2; j <= 9; j++) begin
         step(4'b0100, 1'b0);
         if (j == 5) check_eq("bounce_stable_e5", stable, 4'b0000);
         if (j == 6) check_eq("bounce_stable_e6", stable, 4'b0100);
         if (press_event != 0) ev_cnt++;
         ev_or |= press_event;
      end
      check_eq("bounce_event_bits", ev_or, 4'b0100);
      check_eq("bounce_event_count", 4'(ev_cnt), 4'd1);

      // Latch, then collision of rd_strobe with bit 3's flag set.
      for (int e = 0; e < 8; e++) step(4'b0000, e == 7);
      for (int e = 0; e < 10; e++) step(4'b0010, 1'b0);
`ifdef PB_EDGE_LATCH_EN
      check_eq("latch_pb", pushbuttons, 4'b0010);
      check_eq("latch_any", {3'b000, any_pending}, 4'b0001);
`endif
      for (int e = 1; e <= 8; e++) step(4'b1010, e == 8);
`ifdef PB_EDGE_LATCH_EN
      check_eq("collide_pb", pushbuttons, 4'b1000);
`else
      check_eq("nolatch_pb", pushbuttons, 4'b1010);
      check_eq("nolatch_any", {3'b000, any_pending}, 4'b0000);
`endif
      for (int e = 0; e < 8; e++) step(4'b0000, e == 7);

      // Random stimulus with a reset in the middle.
      pat = '0;
      for (int c = 0; c < 600; ) begin
         pat  = pat ^ 4'($urandom_range(0, 15));
         hold = $urandom_range(1, 7);
         for (int h = 0; h < hold; h++) begin
            step(pat, $urandom_range(0, 4) == 0);
            c++;
         end
         if (c >= 300 && c < 300 + hold) apply_reset(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
